exc_entry_ctrl: RTL and testbench

- Exception entry/return sequencer that drives the write side of the CPSR/SPSR register block (W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Change_M).
- Arbitrates FIQ, IRQ, undefined-instruction and SWI requests at instruction boundaries, and honours the CPSR I/F masks.
- Steps through SPSR save, LR write, CPSR mode switch and vector fetch, and also sequences exception return (SPSR→CPSR restore plus PC reload).
- Sits between decode/interrupt sources and the CPSR/SPSR register block and PC/regfile write ports.

---
 rtl/exc_entry_ctrl_pkg.sv | 72 +++++++
 rtl/exc_entry_ctrl_if.sv | 38 +++
 rtl/exc_entry_ctrl_arbiter.sv | 36 +++
 rtl/exc_entry_ctrl.sv | 158 +++++++++++++++
 tb/tb_exc_entry_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/exc_entry_ctrl_pkg.sv
// Shared types and constants for the exception entry/return sequencer.
// Holds the FSM states, exception kinds, CPSR source codes, bank codes and vector offsets.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SWITCH,
    ST_VECTOR,
    ST_RETURN
  } state_e;

  typedef enum logic [2:0] {
    EXC_UND,
    EXC_SWI,
    EXC_IRQ,
    EXC_FIQ,
    EXC_ERET
  } exc_e;

  localparam logic [2:0] CPSR_SRC_SPSR = 3'd0;
  localparam logic [2:0] CPSR_SRC_NEW  = 3'd1;
  localparam logic [2:0] CPSR_SRC_IRQ  = 3'd2;
  localparam logic [2:0] CPSR_SRC_FIQ  = 3'd3;
  localparam logic [2:0] CPSR_SRC_SVC  = 3'd4;
  localparam logic [2:0] CPSR_SRC_UND  = 3'd5;

  localparam logic [2:0] BANK_CUR = 3'd0;
  localparam logic [2:0] BANK_FIQ = 3'd1;
  localparam logic [2:0] BANK_IRQ = 3'd2;
  localparam logic [2:0] BANK_SVC = 3'd3;
  localparam logic [2:0] BANK_UND = 3'd4;

  localparam logic [31:0] VEC_OFF_UND = 32'h04;
  localparam logic [31:0] VEC_OFF_SWI = 32'h08;
  localparam logic [31:0] VEC_OFF_IRQ = 32'h18;
  localparam logic [31:0] VEC_OFF_FIQ = 32'h1C;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  function automatic logic [2:0] cpsr_code(input exc_e t);
    case (t)
      EXC_UND: return CPSR_SRC_UND;
      EXC_SWI: return CPSR_SRC_SVC;
      EXC_IRQ: return CPSR_SRC_IRQ;
      EXC_FIQ: return CPSR_SRC_FIQ;
      default: return CPSR_SRC_SPSR;
    endcase
  endfunction

  function automatic logic [2:0] bank_of(input exc_e t);
    case (t)
      EXC_UND: return BANK_UND;
      EXC_SWI: return BANK_SVC;
      EXC_IRQ: return BANK_IRQ;
      EXC_FIQ: return BANK_FIQ;
      default: return BANK_CUR;
    endcase
  endfunction

  function automatic logic [31:0] vec_off(input exc_e t);
    case (t)
      EXC_UND: return VEC_OFF_UND;
      EXC_SWI: return VEC_OFF_SWI;
      EXC_IRQ: return VEC_OFF_IRQ;
      EXC_FIQ: return VEC_OFF_FIQ;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/exc_entry_ctrl_if.sv
// Request side and CPSR/SPSR/PC write side of the exception sequencer.
// The master drives requests and CPU state; the slave is the sequencer.
interface exc_entry_ctrl_if;
  logic        irq;
  logic        fiq;
  logic        und_req;
  logic        swi_req;
  logic        eret_req;
  logic [31:0] eret_pc;
  logic        instr_done;
  logic [31:0] cur_pc;
  logic [31:0] cpsr;
  logic        W_SPSR_s;
  logic        Write_SPSR;
  logic [2:0]  W_CPSR_s;
  logic        Write_CPSR;
  logic [2:0]  Change_M;
  logic        lr_write;
  logic [31:0] lr_value;
  logic        pc_write;
  logic [31:0] pc_value;
  logic        flush;
  logic        stall;
  logic        ack;
  logic        busy;

  modport master (
    output irq, fiq, und_req, swi_req, eret_req, eret_pc, instr_done, cur_pc, cpsr,
    input  W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Change_M, lr_write, lr_value,
           pc_write, pc_value, flush, stall, ack, busy
  );

  modport slave (
    input  irq, fiq, und_req, swi_req, eret_req, eret_pc, instr_done, cur_pc, cpsr,
    output W_SPSR_s, Write_SPSR, W_CPSR_s, Write_CPSR, Change_M, lr_write, lr_value,
           pc_write, pc_value, flush, stall, ack, busy
  );
endinterface

// File: rtl/exc_entry_ctrl_arbiter.sv
// Combinational mask and priority selection among pending exception sources.
// An eret from USR/SYS has no SPSR to restore and is turned into an undefined entry.
module exc_arbiter
  import exc_pkg::*;
(
  input  logic       irq_i,
  input  logic       fiq_i,
  input  logic       und_i,
  input  logic       swi_i,
  input  logic       eret_i,
  input  logic       i_mask_i,
  input  logic       f_mask_i,
  input  logic [4:0] mode_i,
  output logic       valid_o,
  output exc_e       type_o
);

  always_comb begin
    valid_o = 1'b1;
    type_o  = EXC_UND;
    if (fiq_i && !f_mask_i) begin
      type_o = EXC_FIQ;
    end else if (irq_i && !i_mask_i) begin
      type_o = EXC_IRQ;
    end else if (und_i) begin
      type_o = EXC_UND;
    end else if (swi_i) begin
      type_o = EXC_SWI;
    end else if (eret_i) begin
      type_o = (mode_i == MODE_USR || mode_i == MODE_SYS) ? EXC_UND : EXC_ERET;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception entry/return sequencer driving the CPSR/SPSR, LR and PC write ports.
// Every output is a flop; the next-output decode is done on the next state.
module exc_entry_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input logic           clk,
  input logic           clr,
  exc_entry_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  exc_e        type_q, type_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] lr_q, lr_d;
  logic        wss_q, wss_d, wsp_q, wsp_d, wc_q, wc_d, lrw_q, lrw_d;
  logic        pcw_q, pcw_d, flush_q, flush_d, stall_q, stall_d;
  logic        ack_q, ack_d, busy_q, busy_d;
  logic [2:0]  wcs_q, wcs_d, cm_q, cm_d;
  logic [31:0] pcv_q, pcv_d;
  logic        arb_valid;
  exc_e        arb_type;

  exc_arbiter u_arb (
    .irq_i    (bus.irq),
    .fiq_i    (bus.fiq),
    .und_i    (bus.und_req),
    .swi_i    (bus.swi_req),
    .eret_i   (bus.eret_req),
    .i_mask_i (bus.cpsr[7]),
    .f_mask_i (bus.cpsr[6]),
    .mode_i   (bus.cpsr[4:0]),
    .valid_o  (arb_valid),
    .type_o   (arb_type)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    tgt_d   = tgt_q;
    lr_d    = lr_q;
    wss_d   = 1'b0;
    wsp_d   = 1'b0;
    wcs_d   = CPSR_SRC_SPSR;
    wc_d    = 1'b0;
    cm_d    = BANK_CUR;
    lrw_d   = 1'b0;
    pcw_d   = 1'b0;
    pcv_d   = '0;
    flush_d = 1'b0;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_done && arb_valid) begin
          type_d = arb_type;
          lr_d   = bus.cur_pc + 32'd4;
          if (arb_type == EXC_ERET) begin
            state_d = ST_RETURN;
            tgt_d   = bus.eret_pc;
          end else begin
            state_d = ST_SAVE;
            tgt_d   = VEC_BASE + vec_off(arb_type);
          end
        end
      end
      ST_SAVE:   state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_VECTOR;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they can be registered.
    case (state_d)
      ST_SAVE: begin
        cm_d  = bank_of(type_d);
        wss_d = 1'b1;
        wsp_d = 1'b1;
        lrw_d = 1'b1;
      end
      ST_SWITCH: begin
        cm_d  = bank_of(type_d);
        wcs_d = cpsr_code(type_d);
        wc_d  = 1'b1;
      end
      ST_VECTOR: begin
        pcw_d   = 1'b1;
        pcv_d   = tgt_d;
        flush_d = 1'b1;
        ack_d   = (type_d == EXC_UND) || (type_d == EXC_SWI);
      end
      ST_RETURN: begin
        wc_d    = 1'b1;
        pcw_d   = 1'b1;
        pcv_d   = tgt_d;
        flush_d = 1'b1;
        ack_d   = 1'b1;
      end
      default: ;
    endcase

    busy_d  = (state_d != ST_IDLE);
    stall_d = busy_d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      type_q  <= EXC_UND;
      tgt_q   <= '0;
      lr_q    <= '0;
      wss_q   <= 1'b0;
      wsp_q   <= 1'b0;
      wcs_q   <= '0;
      wc_q    <= 1'b0;
      cm_q    <= '0;
      lrw_q   <= 1'b0;
      pcw_q   <= 1'b0;
      pcv_q   <= '0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      tgt_q   <= tgt_d;
      lr_q    <= lr_d;
      wss_q   <= wss_d;
      wsp_q   <= wsp_d;
      wcs_q   <= wcs_d;
      wc_q    <= wc_d;
      cm_q    <= cm_d;
      lrw_q   <= lrw_d;
      pcw_q   <= pcw_d;
      pcv_q   <= pcv_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.W_SPSR_s   = wss_q;
  assign bus.Write_SPSR = wsp_q;
  assign bus.W_CPSR_s   = wcs_q;
  assign bus.Write_CPSR = wc_q;
  assign bus.Change_M   = cm_q;
  assign bus.lr_write   = lrw_q;
  assign bus.lr_value   = lr_q;
  assign bus.pc_write   = pcw_q;
  assign bus.pc_value   = pcv_q;
  assign bus.flush      = flush_q;
  assign bus.stall      = stall_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Scoreboard bench for exc_entry_ctrl: stimulus queues expected per-cycle outputs,
// a negedge monitor pops one record for every busy cycle.
module tb_exc_entry_ctrl;

  typedef struct packed {
    logic [2:0]  cm;
    logic        wss;
    logic        wsp;
    logic [2:0]  wcs;
    logic        wc;
    logic        lw;
    logic [31:0] lr;
    logic        pw;
    logic [31:0] pcv;
    logic        fl;
    logic        st;
    logic        ack;
    logic        busy;
  } obs_t;

  logic clk;
  logic clr;
  int   total;
  int   bad;
  obs_t  exp_q[$];
  string name_q[$];

  exc_entry_ctrl_if bus();

  exc_entry_ctrl #(.VEC_BASE(32'h0000_0000)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o.cm   = bus.Change_M;
    o.wss  = bus.W_SPSR_s;
    o.wsp  = bus.Write_SPSR;
    o.wcs  = bus.W_CPSR_s;
    o.wc   = bus.Write_CPSR;
    o.lw   = bus.lr_write;
    o.lr   = bus.lr_value;
    o.pw   = bus.pc_write;
    o.pcv  = bus.pc_value;
    o.fl   = bus.flush;
    o.st   = bus.stall;
    o.ack  = bus.ack;
    o.busy = bus.busy;
    return o;
  endfunction

  function automatic obs_t mk(input logic [2:0] cm, input logic wss, input logic wsp,
                              input logic [2:0] wcs, input logic wc, input logic lw,
                              input logic [31:0] lr, input logic pw, input logic [31:0] pcv,
                              input logic fl, input logic ack);
    obs_t o;
    o.cm = cm; o.wss = wss; o.wsp = wsp; o.wcs = wcs; o.wc = wc; o.lw = lw;
    o.lr = lr; o.pw = pw; o.pcv = pcv; o.fl = fl; o.st = 1'b1; o.ack = ack; o.busy = 1'b1;
    return o;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!clr && bus.busy === 1'b1) begin
      obs_t act, e;
      string n;
      total++;
      act = sample();
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_busy: got %h, required no activity", act);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL %s: got %h required %h", n, act, e);
        end
      end
    end
  end

  task automatic push_entry(input string n, input logic [31:0] lr, input logic [2:0] cm,
                            input logic [2:0] code, input logic [31:0] vec, input logic ackv);
    exp_q.push_back(mk(cm, 1, 1, 3'd0, 0, 1, lr, 0, 32'h0, 0, 0)); name_q.push_back({n, "_save"});
    exp_q.push_back(mk(cm, 0, 0, code, 1, 0, lr, 0, 32'h0, 0, 0)); name_q.push_back({n, "_switch"});
    exp_q.push_back(mk(3'd0, 0, 0, 3'd0, 0, 0, lr, 1, vec, 1, ackv)); name_q.push_back({n, "_vector"});
  endtask

  task automatic issue(input logic i, input logic f, input logic u, input logic s, input logic r,
                       input logic [31:0] cpsr, input logic [31:0] pc, input logic [31:0] epc);
    @(negedge clk);
    bus.irq = i; bus.fiq = f; bus.und_req = u; bus.swi_req = s; bus.eret_req = r;
    bus.cpsr = cpsr; bus.cur_pc = pc; bus.eret_pc = epc;
    bus.instr_done = 1'b1;
    @(negedge clk);
    bus.instr_done = 1'b0;
    bus.irq = 1'b0;
    bus.fiq = 1'b0;
  endtask

  task automatic finish_seq(input string n);
    obs_t act;
    int unsigned cyc;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.und_req = 1'b0; bus.swi_req = 1'b0; bus.eret_req = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", n, bus.busy, cyc);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: %0d records unconsumed, required 0", n, exp_q.size());
      exp_q.delete(); name_q.delete();
    end
    act = sample();
    act.lr = '0;
    total++;
    if (act !== '0) begin
      bad++;
      $display("FAIL %s_idle: got %h required 0", n, act);
    end
  endtask

  initial begin
    obs_t act;
    total = 0; bad = 0;
    bus.irq = 0; bus.fiq = 0; bus.und_req = 0; bus.swi_req = 0; bus.eret_req = 0;
    bus.eret_pc = '0; bus.instr_done = 0; bus.cur_pc = '0; bus.cpsr = 32'h10;
    clr = 1'b1;
    #1;
    act = sample();
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_state: got %h required 0", act); end
    repeat (2) @(negedge clk);
    clr = 1'b0;

    push_entry("irq", 32'h104, 3'd2, 3'd2, 32'h18, 1'b0);
    issue(1, 0, 0, 0, 0, 32'h10, 32'h100, 32'h0);
    finish_seq("irq");

    push_entry("fiq_over_irq", 32'h204, 3'd1, 3'd3, 32'h1C, 1'b0);
    issue(1, 1, 0, 0, 0, 32'h10, 32'h200, 32'h0);
    finish_seq("fiq_over_irq");

    push_entry("fiq_masked", 32'h284, 3'd2, 3'd2, 32'h18, 1'b0);
    issue(1, 1, 0, 0, 0, 32'h50, 32'h280, 32'h0);
    finish_seq("fiq_masked");

    push_entry("swi_irq_masked", 32'h304, 3'd3, 3'd4, 32'h08, 1'b1);
    issue(1, 0, 0, 1, 0, 32'h92, 32'h300, 32'h0);
    finish_seq("swi_irq_masked");

    push_entry("und", 32'h404, 3'd4, 3'd5, 32'h04, 1'b1);
    issue(0, 0, 1, 0, 0, 32'h13, 32'h400, 32'h0);
    finish_seq("und");

    exp_q.push_back(mk(3'd0, 0, 0, 3'd0, 1, 0, 32'h504, 1, 32'h204, 1, 1));
    name_q.push_back("eret_return");
    issue(0, 0, 0, 0, 1, 32'h92, 32'h500, 32'h204);
    finish_seq("eret");

    push_entry("eret_usr", 32'h604, 3'd4, 3'd5, 32'h04, 1'b1);
    issue(0, 0, 0, 0, 1, 32'h10, 32'h600, 32'h204);
    finish_seq("eret_usr");

    push_entry("eret_sys", 32'h684, 3'd4, 3'd5, 32'h04, 1'b1);
    issue(0, 0, 0, 0, 1, 32'h1F, 32'h680, 32'h208);
    finish_seq("eret_sys");

    push_entry("und_both_masked", 32'h704, 3'd4, 3'd5, 32'h04, 1'b1);
    issue(1, 1, 1, 0, 0, 32'hD3, 32'h700, 32'h0);
    finish_seq("und_both_masked");

    // irq without instr_done is ignored; any busy cycle trips the monitor
    @(negedge clk);
    bus.irq = 1'b1; bus.cpsr = 32'h10; bus.instr_done = 1'b0;
    repeat (3) @(negedge clk);
    bus.irq = 1'b0;
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL no_boundary: busy=%b required 0", bus.busy); end

    // reset while in SWITCH
    exp_q.push_back(mk(3'd2, 1, 1, 3'd0, 0, 1, 32'h804, 0, 32'h0, 0, 0));
    name_q.push_back("clr_save");
    issue(1, 0, 0, 0, 0, 32'h10, 32'h800, 32'h0);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    act = sample();
    total++;
    if (act !== '0) begin bad++; $display("FAIL clr_mid_seq: got %h required 0", act); end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL clr_save_seen: %0d records unconsumed, required 0", exp_q.size());
      exp_q.delete(); name_q.delete();
    end
    @(negedge clk);
    clr = 1'b0;

    push_entry("irq_after_clr", 32'h904, 3'd2, 3'd2, 32'h18, 1'b0);
    issue(1, 0, 0, 0, 0, 32'h10, 32'h900, 32'h0);
    finish_seq("irq_after_clr");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
